// File: rtl/lcd_backlight_sched.sv
// Backlight level scheduler: user setting, idle dimming and a sleep force-off feed one target level.
// Define LCD_BL_FADE_EN to fade one step per STEP_US; left undefined, level follows target directly.
module lcd_backlight_sched #(
   parameter int CLK_HZ     = 27000000,
   parameter int STEP_US    = 1000,
   parameter int IDLE_MS    = 30000,
   parameter int DIM_LEVEL  = 4,
   parameter int INIT_LEVEL = 16
) (
   input  logic       clk,
   input  logic       srst,
   input  logic [4:0] user_level,
   input  logic       user_valid,
   output logic       user_ready,
   input  logic       activity,
   input  logic       sleep_req,
   output logic [4:0] level,
   output logic       busy,
   output logic       dimmed
);
   localparam longint MS_DIV_RAW = longint'(CLK_HZ) / 1000;
   localparam longint MS_DIV     = (MS_DIV_RAW < 1) ? 1 : MS_DIV_RAW;
   localparam int     MS_W       = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam int     IDLE_W     = $clog2(IDLE_MS + 1);

   localparam logic [MS_W-1:0]   MS_LAST  = MS_W'(MS_DIV - 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_MS);
   localparam logic [4:0]        DIM_L    = 5'(DIM_LEVEL);
   localparam logic [4:0]        INIT_L   = 5'(INIT_LEVEL);

   logic [4:0]        user_set;
   logic [4:0]        target;
   logic [MS_W-1:0]   ms_cnt;
   logic [IDLE_W-1:0] idle_cnt;
   logic              accept;
   logic              clear;
   logic              ms_tick;

   assign user_ready = !sleep_req && !srst;
   assign accept     = user_valid && user_ready;
   assign clear      = activity || accept;
   assign ms_tick    = (ms_cnt == MS_LAST);

   always_comb begin
      if (sleep_req)
         target = '0;
      else if (dimmed)
         target = (user_set < DIM_L) ? user_set : DIM_L;
      else
         target = user_set;
   end

   // NOTE: every register here uses <= so all state updates see the same pre-edge values.
   always_ff @(posedge clk) begin
      if (srst)
         user_set <= INIT_L;
      else if (accept)
         user_set <= user_level;
   end

   // The prescaler restarts with the idle count so the timeout is exactly IDLE_MS after the last event.
   always_ff @(posedge clk) begin
      if (srst || sleep_req || clear) begin
         ms_cnt   <= '0;
         idle_cnt <= '0;
         dimmed   <= 1'b0;
      end else begin
         ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
         if (ms_tick && idle_cnt != IDLE_MAX)
            idle_cnt <= idle_cnt + 1'b1;
         if (idle_cnt == IDLE_MAX)
            dimmed <= 1'b1;
      end
   end

`ifdef LCD_BL_FADE_EN
   localparam longint STEP_RAW  = (longint'(CLK_HZ) / 1000000) * longint'(STEP_US);
   localparam longint STEP_DIV  = (STEP_RAW < 1) ? 1 : STEP_RAW;
   localparam int     STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

   typedef enum logic {ST_IDLE, ST_RAMP} state_t;

   state_t            state;
   logic [STEP_W-1:0] step_cnt;
   logic [4:0]        level_step;

   // Only used while level != target, so it can never wrap past 0 or 31.
   assign level_step = (target > level) ? level + 5'd1 : level - 5'd1;

   always_ff @(posedge clk) begin
      if (srst) begin
         state    <= ST_IDLE;
         level    <= '0;
         step_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (target != level) begin
                  state    <= ST_RAMP;
                  step_cnt <= '0;
               end
            end
            ST_RAMP: begin
               if (target == level) begin
                  state <= ST_IDLE;
               end else if (step_cnt == STEP_LAST) begin
                  step_cnt <= '0;
                  level    <= level_step;
                  if (level_step == target)
                     state <= ST_IDLE;
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign busy = (state == ST_RAMP);
`else
   always_ff @(posedge clk) begin
      if (srst)
         level <= '0;
      else
         level <= target;
   end

   // High only for the single cycle in which level is catching up with target.
   assign busy = !srst && (level != target);
`endif

endmodule

// File: doc/lcd_backlight_sched.md
LCD_BACKLIGHT_SCHED -- requirements
Module: lcd_backlight_sched

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27000000, system clock frequency in Hz.
REQ-002 SHALL have parameter STEP_US, default 1000, fade step interval in microseconds (legal range >= 1).
REQ-003 SHALL have parameter IDLE_MS, default 30000, inactivity timeout in milliseconds (legal range >= 1).
REQ-004 SHALL have parameter DIM_LEVEL, default 4, 5-bit level used while dimmed (legal range 0..31).
REQ-005 SHALL have parameter INIT_LEVEL, default 16, user setting loaded at reset.
REQ-006 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-007 SHALL have port srst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port user_level  input  5  requested brightness.
REQ-009 SHALL have port user_valid  input  1  user_level request valid.
REQ-010 SHALL have port user_ready  output  1  request can be accepted.
REQ-011 SHALL have port activity  input  1  single-cycle pulse on any key or touch event.
REQ-012 SHALL have port sleep_req  input  1  level-sensitive force-off from the power manager.
REQ-013 SHALL have port level  output  5  brightness to the EZDim driver; registered.
REQ-014 SHALL have port busy  output  1  high while level != target.
REQ-015 SHALL have port dimmed  output  1  high while the inactivity timeout is active.

Function
REQ-016 SHALL accept a request on a cycle with user_valid && user_ready, storing user_level into user_set (visible the next cycle); user_ready = !sleep_req && !srst.
REQ-017 SHALL compute target with priority: sleep_req -> 0; else dimmed -> min(user_set, DIM_LEVEL); else user_set.
REQ-018 SHALL generate a 1 ms tick from a CLK_HZ/1000 prescaler and count idle ticks, saturating at IDLE_MS.
REQ-019 SHALL clear the idle count and dimmed on an activity pulse or an accepted request; when both occur in the same cycle as reaching IDLE_MS, the clear wins.
REQ-020 SHALL set dimmed on the cycle after the idle count reaches IDLE_MS; dimmed SHALL clear one cycle after the clearing event.
REQ-021 SHALL hold the idle count at 0 and dimmed at 0 while sleep_req is high.
REQ-022 SHALL use FSM states ST_IDLE (level == target) and ST_RAMP (level != target); ST_IDLE -> ST_RAMP when target != level; ST_RAMP -> ST_IDLE when level == target.
REQ-023 SHALL restart the step timer (period CLK_HZ/1000000*STEP_US cycles) on ST_IDLE -> ST_RAMP, with the first step one full interval after entry.
REQ-024 SHALL move level by exactly +/-1 toward the current target on each step tick in ST_RAMP; level SHALL never wrap past 0 or 31.
REQ-025 SHALL continue from the current level toward a new target when target changes mid-ramp, without restarting the step timer; if the new target equals level, SHALL go to ST_IDLE next cycle.
REQ-026 SHALL drive busy = (state == ST_RAMP).
REQ-027 SHALL size every counter as $clog2(max+1) bits; no truncation of parameter products.

Reset
REQ-028 SHALL reset: level = 0, user_set = INIT_LEVEL, dimmed = 0, busy = 0, state = ST_IDLE, all counters = 0; after release, SHALL ramp 0 -> INIT_LEVEL.
REQ-029 SHALL abandon any ramp when srst is asserted mid-operation, with outputs at reset values the next cycle.

Configuration
REQ-030 SHALL compile fading under macro LCD_BL_FADE_EN: if defined, REQ-022..REQ-026 apply; if undefined, level SHALL load target one cycle after target changes, busy SHALL be high for that single cycle only, and the step timer SHALL be omitted.

Verification
REQ-031 Bench parameters: CLK_HZ=1000000, STEP_US=10, IDLE_MS=2, DIM_LEVEL=4, INIT_LEVEL=16, fade enabled.
REQ-032 Release reset -> level steps 0..16, one step every 10 cycles, busy high throughout, busy low after level reaches 16 (~160 cycles).
REQ-033 Accept user_level=20 during the ramp at level=8 -> ramp continues to 20 with no reversal, then idle; request user_level=3 -> ramp down to 3.
REQ-034 No activity for 2000 cycles with user_set=20 -> dimmed=1 and level ramps down to 4; activity pulse -> dimmed=0 next cycle and level ramps back up to 20.
REQ-035 Assert sleep_req with user_valid=1 and user_level=31 -> user_ready=0, request not taken, level ramps to 0; deassert -> level ramps back to the prior user_set.
REQ-036 Assert srst at level=10 mid-ramp -> level=0, user_set=16, busy=0 next cycle; with LCD_BL_FADE_EN undefined, a request of 25 -> level=25 one cycle after the request is stored.
